minimig_autoconfig_ctrl: RTL and testbench

Bus-side Zorro AutoConfig responder for the Minimig core. It walks the configured board slots in order and serves CPU reads in the $E80000 config space from the 4-bit AutoConfig nibble ROM. It accepts the base-address writes that configure each board and reports every assigned base to the memory and peripheral decoders.

---
 rtl/minimig_autoconfig_pkg.sv | 25 ++
 rtl/minimig_autoconfig_slotsel.sv | 19 +
 rtl/minimig_autoconfig_ctrl.sv | 137 +++++++++++++
 tb/tb_minimig_autoconfig_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minimig_autoconfig_pkg.sv
// minimig_autoconfig_pkg: slot indices, config-space offsets and FSM states for the AutoConfig responder
package minimig_autoconfig_pkg;
  typedef enum logic [2:0] {
    SLOT_Z2,
    SLOT_Z3,
    SLOT_Z3B2,
    SLOT_Z3B3,
    SLOT_ETH,
    SLOT_SND,
    SLOT_CTRL
  } slot_t;
  localparam logic [7:0] OFF_Z3BASE  = 8'h44;
  localparam logic [7:0] OFF_Z2HI    = 8'h48;
  localparam logic [7:0] OFF_Z2LO    = 8'h4A;
  localparam logic [7:0] OFF_SHUTUP  = 8'h4C;
  localparam logic [7:0] OFF_ROM_END = 8'h40;
  typedef enum logic [2:0] {
    S_SKIP,
    S_FETCH,
    S_IDLE,
    S_RDWAIT,
    S_ACK,
    S_DONE
  } state_t;
endpackage

// File: rtl/minimig_autoconfig_slotsel.sv
// minimig_autoconfig_slotsel: lowest enabled slot at or above cur, none_left when there is none
module minimig_autoconfig_slotsel #(
  parameter int SLOTS = 7
) (
  input  logic [SLOTS-1:0] slot_en,
  input  logic [3:0]       cur,
  output logic [2:0]       next_slot,
  output logic             none_left
);
  always_comb begin
    next_slot = '0;
    none_left = 1'b1;
    for (int i = SLOTS - 1; i >= 0; i--)
      if (slot_en[i] && 4'(i) >= cur) begin
        next_slot = 3'(i);
        none_left = 1'b0;
      end
  end
endmodule

// File: rtl/minimig_autoconfig_ctrl.sv
// minimig_autoconfig_ctrl: Zorro AutoConfig responder walking board slots; define MINIMIG_AUTOCONFIG_SHUTUP_EN to accept 0x4C shut-up writes
module minimig_autoconfig_ctrl
  import minimig_autoconfig_pkg::*;
#(
  parameter int SLOTS = SLOT_CTRL + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SLOTS-1:0] slot_en,
  input  logic             sel,
  input  logic             rd,
  input  logic             wr,
  input  logic [6:0]       addr,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata,
  output logic             ack,
  output logic [8:0]       rom_addr,
  input  logic [3:0]       rom_q,
  output logic             cfg_valid,
  output logic [2:0]       cfg_slot,
  output logic [15:0]      cfg_base,
  output logic             cfg_shutup,
  output logic [SLOTS-1:0] configured,
  output logic             done
);
`ifdef MINIMIG_AUTOCONFIG_SHUTUP_EN
  localparam bit SHUT_EN = 1'b1;
`else
  localparam bit SHUT_EN = 1'b0;
`endif
  state_t state;
  logic [3:0] cur;
  logic [3:0] z2lo;
  logic cnt, is_z3, sel_q, pend;
  logic [2:0] next_slot;
  logic none_left;
  logic [7:0] off;
  logic req, is_rd, rom_rd, set_lo, fin_z2, fin_z3, fin_sh, fin;
  minimig_autoconfig_slotsel #(.SLOTS(SLOTS)) u_slotsel (
    .slot_en(slot_en),
    .cur(cur),
    .next_slot(next_slot),
    .none_left(none_left)
  );
  assign off    = {addr, 1'b0};
  assign req    = (sel & ~sel_q) | pend;
  assign is_rd  = rd & ~wr;
  assign rom_rd = is_rd & (off < OFF_ROM_END);
  assign set_lo = wr & ~is_z3 & (off == OFF_Z2LO);
  assign fin_z2 = wr & ~is_z3 & (off == OFF_Z2HI);
  assign fin_z3 = wr & is_z3 & (off == OFF_Z3BASE);
  assign fin_sh = SHUT_EN & wr & (off == OFF_SHUTUP);
  assign fin    = fin_z2 | fin_z3 | fin_sh;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= S_SKIP;
      cur        <= '0;
      z2lo       <= '0;
      cnt        <= 1'b0;
      is_z3      <= 1'b0;
      sel_q      <= 1'b0;
      pend       <= 1'b0;
      rdata      <= 16'hFFFF;
      ack        <= 1'b0;
      rom_addr   <= '0;
      cfg_valid  <= 1'b0;
      cfg_slot   <= '0;
      cfg_base   <= '0;
      cfg_shutup <= 1'b0;
      configured <= '0;
      done       <= 1'b0;
    end else begin
      sel_q     <= sel;
      pend      <= req;
      ack       <= 1'b0;
      cfg_valid <= 1'b0;
      case (state)
        S_SKIP:
          if (none_left) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cur      <= {1'b0, next_slot};
            rom_addr <= {next_slot, 6'h00};
            cnt      <= 1'b0;
            state    <= S_FETCH;
          end
        S_FETCH: begin
          cnt <= 1'b1;
          if (cnt) begin
            is_z3 <= rom_q[3:2] == 2'b10;
            state <= S_IDLE;
          end
        end
        S_IDLE:
          if (req) begin
            pend <= 1'b0;
            if (rom_rd) begin
              rom_addr <= {cur[2:0], addr[5:0]};
              cnt      <= 1'b0;
              state    <= S_RDWAIT;
            end else begin
              ack <= 1'b1;
              if (is_rd) rdata <= 16'hFFFF;
              if (set_lo) z2lo <= wdata[15:12];
              if (fin) begin
                cfg_valid  <= 1'b1;
                cfg_slot   <= cur[2:0];
                cfg_base   <= fin_z3 ? wdata : fin_z2 ? {8'h00, wdata[15:12], z2lo} : 16'h0000;
                cfg_shutup <= fin_sh;
                configured <= configured | (SLOTS'(1) << cur);
                cur        <= cur + 4'd1;
                z2lo       <= '0;
                state      <= S_SKIP;
              end else
                state <= S_ACK;
            end
          end
        S_RDWAIT: begin
          cnt <= 1'b1;
          if (cnt) begin
            rdata <= {rom_q, 12'hFFF};
            ack   <= 1'b1;
            state <= S_ACK;
          end
        end
        S_ACK: state <= S_IDLE;
        S_DONE:
          if (req) begin
            pend <= 1'b0;
            ack  <= 1'b1;
            if (is_rd) rdata <= 16'hFFFF;
          end
        default: state <= S_SKIP;
      endcase
    end
endmodule

// File: tb/tb_minimig_autoconfig_ctrl.sv
// tb_minimig_autoconfig_ctrl: randomized self-checking bench for the AutoConfig responder
module tb_minimig_autoconfig_ctrl;
  localparam int SLOTS = 7;
`ifdef MINIMIG_AUTOCONFIG_SHUTUP_EN
  localparam bit SHUT_EN = 1'b1;
`else
  localparam bit SHUT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [SLOTS-1:0] slot_en = '0;
  logic sel = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [6:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic ack;
  logic [8:0] rom_addr;
  logic [3:0] rom_q;
  logic cfg_valid;
  logic [2:0] cfg_slot;
  logic [15:0] cfg_base;
  logic cfg_shutup;
  logic [SLOTS-1:0] configured;
  logic done;
  logic [3:0] rom [0:511];
  int total = 0, bad = 0, ack_cnt = 0, cv_cnt = 0;
  bit watch = 1'b0, stray = 1'b0;
  int m_cur;
  bit m_done;
  logic [3:0] m_lo;
  logic [SLOTS-1:0] m_cfg;
  logic [15:0] m_rdata;
  int o_lat;
  logic [15:0] o_rdata, o_base;
  logic o_cv, o_sh;
  logic [2:0] o_slot;

  minimig_autoconfig_ctrl #(.SLOTS(SLOTS)) dut (
    .clk(clk), .reset_n(reset_n), .slot_en(slot_en), .sel(sel), .rd(rd), .wr(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .rom_addr(rom_addr),
    .rom_q(rom_q), .cfg_valid(cfg_valid), .cfg_slot(cfg_slot), .cfg_base(cfg_base),
    .cfg_shutup(cfg_shutup), .configured(configured), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom[rom_addr];
  always @(negedge clk) begin
    if (ack) ack_cnt++;
    if (cfg_valid) cv_cnt++;
    if (!watch) stray = 1'b0;
    else if (rom_addr[8:6] < 3'd4 || rom_addr[8:6] == 3'd5) stray = 1'b1;
  end

  function automatic int m_next(input int from);
    for (int i = from; i < SLOTS; i++) if (slot_en[i]) return i;
    return -1;
  endfunction

  function automatic bit m_z3();
    return rom[m_cur * 64][3:2] == 2'b10;
  endfunction

  task automatic m_walk(input int from);
    int n;
    n = m_next(from);
    m_lo = 4'h0;
    if (n < 0) m_done = 1'b1;
    else m_cur = n;
  endtask

  task automatic m_reset();
    m_cur = 0; m_done = 1'b0; m_cfg = '0; m_rdata = 16'hFFFF;
    m_walk(0);
  endtask

  task automatic m_access(input bit r, input bit w, input logic [7:0] off, input logic [15:0] d,
                          output logic [15:0] e_rdata, output bit e_cv, output logic [15:0] e_base,
                          output bit e_sh, output int e_lat, output int e_slot);
    bit fin;
    fin = 1'b0; e_cv = 1'b0; e_base = 16'h0; e_sh = 1'b0; e_lat = 1; e_slot = m_cur;
    if (m_done) begin
      if (r && !w) m_rdata = 16'hFFFF;
    end else if (w) begin
      if (!m_z3() && off == 8'h4A) m_lo = d[15:12];
      else if (!m_z3() && off == 8'h48) begin fin = 1'b1; e_base = {8'h00, d[15:12], m_lo}; end
      else if (m_z3() && off == 8'h44) begin fin = 1'b1; e_base = d; end
      else if (SHUT_EN && off == 8'h4C) begin fin = 1'b1; e_sh = 1'b1; end
    end else if (r) begin
      if (off < 8'h40) begin m_rdata = {rom[m_cur * 64 + int'(off) / 2], 12'hFFF}; e_lat = 3; end
      else m_rdata = 16'hFFFF;
    end
    if (fin) begin
      e_cv = 1'b1;
      m_cfg[m_cur] = 1'b1;
      m_walk(m_cur + 1);
    end
    e_rdata = m_rdata;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 512; i++) rom[i] = 4'($urandom);
  endtask

  task automatic settle();
    repeat (SLOTS + 4) @(negedge clk);
  endtask

  task automatic do_reset(input logic [SLOTS-1:0] en);
    reset_n = 1'b0; sel = 1'b0; rd = 1'b0; wr = 1'b0; slot_en = en;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic access(input bit r, input bit w, input logic [7:0] off, input logic [15:0] d);
    int n;
    n = 0;
    sel = 1'b1; rd = r; wr = w; addr = off[7:1]; wdata = d;
    do begin @(negedge clk); n++; end while (!ack && n < 40);
    o_lat = ack ? n : -1;
    o_rdata = rdata; o_cv = cfg_valid; o_slot = cfg_slot; o_base = cfg_base; o_sh = cfg_shutup;
    sel = 1'b0; rd = 1'b0; wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    slot_en = 7'h03;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (rdata !== 16'hFFFF) begin bad++; $display("FAIL reset_rdata: got %h want ffff", rdata); end
    total++; if (rom_addr !== 9'h000) begin bad++; $display("FAIL reset_rom_addr: got %h want 000", rom_addr); end
    total++; if ({ack, cfg_valid, cfg_shutup, done} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {ack, cfg_valid, cfg_shutup, done}); end
    total++; if ({cfg_slot, cfg_base, configured} !== 26'h0) begin bad++; $display("FAIL reset_cfg: got %h want 0", {cfg_slot, cfg_base, configured}); end
    reset_n = 1'b1;
  endtask

  task automatic test_z2_config();
    rom[0] = 4'hE; rom[1] = 4'h0; rom[64] = 4'hA;
    do_reset(7'h03); settle();
    access(1'b1, 1'b0, 8'h02, 16'h0);
    total++; if (o_rdata !== 16'h0FFF) begin bad++; $display("FAIL z2_read_rdata: got %h want 0fff", o_rdata); end
    total++; if (o_lat !== 3) begin bad++; $display("FAIL z2_read_latency: got %0d want 3", o_lat); end
    access(1'b0, 1'b1, 8'h4A, 16'h2000);
    total++; if (o_lat !== 1 || o_cv !== 1'b0) begin bad++; $display("FAIL z2_lo_write: got lat=%0d cv=%b want lat=1 cv=0", o_lat, o_cv); end
    access(1'b0, 1'b1, 8'h48, 16'h4000);
    total++; if ({o_cv, o_slot, o_base} !== {1'b1, 3'd0, 16'h0042}) begin bad++; $display("FAIL z2_complete: got cv=%b slot=%0d base=%h want cv=1 slot=0 base=0042", o_cv, o_slot, o_base); end
    total++; if (configured !== 7'h01) begin bad++; $display("FAIL z2_configured: got %h want 01", configured); end
  endtask

  task automatic test_z3_done();
    settle();
    access(1'b0, 1'b1, 8'h44, 16'h4000);
    total++; if ({o_cv, o_slot, o_base} !== {1'b1, 3'd1, 16'h4000}) begin bad++; $display("FAIL z3_complete: got cv=%b slot=%0d base=%h want cv=1 slot=1 base=4000", o_cv, o_slot, o_base); end
    settle();
    total++; if (done !== 1'b1 || configured !== 7'h03) begin bad++; $display("FAIL z3_done: got done=%b cfg=%h want done=1 cfg=03", done, configured); end
    access(1'b1, 1'b0, 8'h00, 16'h0);
    total++; if (o_rdata !== 16'hFFFF || o_lat !== 1) begin bad++; $display("FAIL done_read: got %h lat=%0d want ffff lat=1", o_rdata, o_lat); end
    access(1'b0, 1'b1, 8'h48, 16'h1234);
    total++; if (o_cv !== 1'b0 || o_lat !== 1) begin bad++; $display("FAIL done_write: got cv=%b lat=%0d want cv=0 lat=1", o_cv, o_lat); end
  endtask

  task automatic test_sparse();
    rom[9'h100] = 4'hE; rom[9'h180] = 4'hA;
    do_reset(7'h50); settle();
    watch = 1'b1;
    access(1'b1, 1'b0, 8'h06, 16'h0);
    total++; if (rom_addr !== 9'h103 || o_rdata !== {rom[9'h103], 12'hFFF}) begin bad++; $display("FAIL sparse_read4: got addr=%h rdata=%h want addr=103 rdata=%h", rom_addr, o_rdata, {rom[9'h103], 12'hFFF}); end
    total++; if (o_lat !== 3) begin bad++; $display("FAIL sparse_latency: got %0d want 3", o_lat); end
    access(1'b0, 1'b1, 8'h4A, 16'h7000);
    access(1'b0, 1'b1, 8'h48, 16'h9000);
    total++; if ({o_cv, o_slot, o_base} !== {1'b1, 3'd4, 16'h0097}) begin bad++; $display("FAIL sparse_z2: got cv=%b slot=%0d base=%h want cv=1 slot=4 base=0097", o_cv, o_slot, o_base); end
    access(1'b1, 1'b0, 8'h04, 16'h0);
    total++; if (rom_addr !== 9'h182 || o_rdata !== {rom[9'h182], 12'hFFF} || o_lat < 0) begin bad++; $display("FAIL sparse_pending_read6: got addr=%h rdata=%h lat=%0d want addr=182 rdata=%h", rom_addr, o_rdata, o_lat, {rom[9'h182], 12'hFFF}); end
    access(1'b0, 1'b1, 8'h44, 16'hBEEF);
    total++; if ({o_cv, o_slot, o_base} !== {1'b1, 3'd6, 16'hBEEF}) begin bad++; $display("FAIL sparse_z3: got cv=%b slot=%0d base=%h want cv=1 slot=6 base=beef", o_cv, o_slot, o_base); end
    settle();
    total++; if (stray !== 1'b0) begin bad++; $display("FAIL sparse_stray_slot: got %b want 0", stray); end
    total++; if (done !== 1'b1 || configured !== 7'h50) begin bad++; $display("FAIL sparse_done: got done=%b cfg=%h want done=1 cfg=50", done, configured); end
    watch = 1'b0;
  endtask

  task automatic test_shutup();
    logic [15:0] er, eb;
    bit ecv, esh;
    int el, es;
    rom[0] = 4'hE; rom[64] = 4'hA;
    do_reset(7'h03); settle();
    m_access(1'b0, 1'b1, 8'h4C, 16'h5A5A, er, ecv, eb, esh, el, es);
    access(1'b0, 1'b1, 8'h4C, 16'h5A5A);
    total++; if (o_cv !== ecv || o_lat !== el) begin bad++; $display("FAIL shutup_valid: got cv=%b lat=%0d want cv=%b lat=%0d", o_cv, o_lat, ecv, el); end
    if (ecv) begin
      total++; if ({o_sh, o_base, o_slot} !== {esh, eb, 3'(es)}) begin bad++; $display("FAIL shutup_fields: got sh=%b base=%h slot=%0d want sh=%b base=%h slot=%0d", o_sh, o_base, o_slot, esh, eb, es); end
    end
    total++; if (configured !== m_cfg) begin bad++; $display("FAIL shutup_configured: got %h want %h", configured, m_cfg); end
    settle();
    m_access(1'b1, 1'b0, 8'h00, 16'h0, er, ecv, eb, esh, el, es);
    access(1'b1, 1'b0, 8'h00, 16'h0);
    total++; if (o_rdata !== er) begin bad++; $display("FAIL shutup_next_read: got %h want %h", o_rdata, er); end
  endtask

  task automatic test_rdwr_both();
    rom[0] = 4'hE;
    do_reset(7'h03); settle();
    access(1'b0, 1'b1, 8'h4A, 16'h5000);
    access(1'b1, 1'b1, 8'h48, 16'h3000);
    total++; if ({o_cv, o_slot, o_base} !== {1'b1, 3'd0, 16'h0035} || o_lat !== 1) begin bad++; $display("FAIL rdwr_as_write: got cv=%b slot=%0d base=%h lat=%0d want cv=1 slot=0 base=0035 lat=1", o_cv, o_slot, o_base, o_lat); end
  endtask

  task automatic test_held_sel();
    int a0;
    settle();
    a0 = ack_cnt;
    sel = 1'b1; rd = 1'b1; wr = 1'b0; addr = 7'h20;
    repeat (10) @(negedge clk);
    sel = 1'b0; rd = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ack_cnt - a0 !== 1) begin bad++; $display("FAIL held_sel_acks: got %0d want 1", ack_cnt - a0); end
    total++; if (rdata !== 16'hFFFF) begin bad++; $display("FAIL held_sel_rdata: got %h want ffff", rdata); end
  endtask

  task automatic test_reset_midread();
    int a0;
    rom[0] = 4'hE;
    do_reset(7'h03); settle();
    access(1'b0, 1'b1, 8'h4A, 16'h1000);
    access(1'b0, 1'b1, 8'h48, 16'h2000);
    settle();
    sel = 1'b1; rd = 1'b1; wr = 1'b0; addr = 7'h08;
    repeat (2) @(negedge clk);
    a0 = ack_cnt;
    reset_n = 1'b0; sel = 1'b0; rd = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ack_cnt !== a0 || ack !== 1'b0) begin bad++; $display("FAIL reset_midread_ack: got %0d acks want 0", ack_cnt - a0); end
    reset_n = 1'b1;
    m_reset();
    total++; if (configured !== 7'h00) begin bad++; $display("FAIL reset_midread_configured: got %h want 00", configured); end
    settle();
    access(1'b1, 1'b0, 8'h00, 16'h0);
    total++; if (o_rdata !== {rom[0], 12'hFFF} || rom_addr !== 9'h000) begin bad++; $display("FAIL reset_midread_slot0: got rdata=%h addr=%h want rdata=%h addr=000", o_rdata, rom_addr, {rom[0], 12'hFFF}); end
  endtask

  task automatic test_random();
    logic [15:0] er, eb, d;
    logic [7:0] off;
    bit ecv, esh, r, w;
    int el, es, nfin, cv0;
    for (int k = 0; k < 6; k++) begin
      fill_rom();
      do_reset(7'($urandom_range(1, 127))); settle();
      nfin = 0; cv0 = cv_cnt;
      for (int j = 0; j < 30; j++) begin
        d = 16'($urandom);
        r = 1'b0; w = 1'b1;
        case ($urandom_range(0, 6))
          0: begin r = 1'b1; w = 1'b0; off = 8'($urandom_range(0, 31) * 2); end
          1: begin r = 1'b1; w = 1'b0; off = 8'($urandom_range(32, 127) * 2); end
          2: begin off = 8'h4A; r = ($urandom_range(0, 3) == 0); end
          3: begin off = 8'h48; r = ($urandom_range(0, 3) == 0); end
          4: off = 8'h44;
          5: off = 8'($urandom_range(0, 127) * 2);
          default: off = 8'h4C;
        endcase
        m_access(r, w, off, d, er, ecv, eb, esh, el, es);
        access(r, w, off, d);
        total++; if (o_lat !== el) begin bad++; $display("FAIL rand_latency off=%h: got %0d want %0d", off, o_lat, el); end
        if (r && !w) begin
          total++; if (o_rdata !== er) begin bad++; $display("FAIL rand_rdata off=%h: got %h want %h", off, o_rdata, er); end
        end
        total++; if (o_cv !== ecv) begin bad++; $display("FAIL rand_cfg_valid off=%h: got %b want %b", off, o_cv, ecv); end
        if (ecv) begin
          nfin++;
          total++; if ({o_slot, o_base, o_sh} !== {3'(es), eb, esh}) begin bad++; $display("FAIL rand_cfg_fields: got slot=%0d base=%h sh=%b want slot=%0d base=%h sh=%b", o_slot, o_base, o_sh, es, eb, esh); end
          settle();
        end
        total++; if (configured !== m_cfg || done !== m_done) begin bad++; $display("FAIL rand_state: got cfg=%h done=%b want cfg=%h done=%b", configured, done, m_cfg, m_done); end
      end
      total++; if (cv_cnt - cv0 !== nfin) begin bad++; $display("FAIL rand_cfg_pulses: got %0d want %0d", cv_cnt - cv0, nfin); end
    end
  endtask

  initial begin
    fill_rom();
    test_reset();
    test_z2_config();
    test_z3_done();
    test_sparse();
    test_shutup();
    test_rdwr_both();
    test_held_sel();
    test_reset_midread();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
